// File: rtl/uf_pkg.sv
// Shared types for the union-find command issuer: op encodings, FSM states, command record.
package uf_pkg;

    // Element width carried in the command record; the issuer's ELEM_W must match it.
    localparam int unsigned UF_ELEM_W = 4;

    localparam logic [1:0] UF_OP_NOP   = 2'd0;
    localparam logic [1:0] UF_OP_UNION = 2'd1;
    localparam logic [1:0] UF_OP_FIND  = 2'd2;
    localparam logic [1:0] UF_OP_RSVD  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } uf_state_e;

    typedef struct packed {
        logic [1:0]           op;
        logic [UF_ELEM_W-1:0] x;
        logic [UF_ELEM_W-1:0] y;
    } uf_cmd_t;

endpackage

// File: rtl/uf_cmd_fifo.sv
// Synchronous command FIFO; power-of-two depth, extra pointer bit separates full from empty.
module uf_cmd_fifo
    import uf_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  uf_cmd_t push_data,
    input  logic    pop,
    output uf_cmd_t pop_data,
    output logic    full,
    output logic    empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uf_cmd_fifo: DEPTH must be a power of two >= 2");
    end

    uf_cmd_t     mem_q [DEPTH];
    uf_cmd_t     mem_d [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        do_push;
    logic        do_pop;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: contents are only read behind a valid pointer.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/uf_op_issuer.sv
// Union-find command issuer: queues commands, issues one core op at a time, returns find roots.
// Optional input range checking and error counting with `define UF_RANGE_CHECK_EN.
module uf_op_issuer
    import uf_pkg::*;
#(
    parameter int unsigned SIZE       = 10,
    parameter int unsigned ELEM_W     = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ELEM_W-1:0] cmd_x,
    input  logic [ELEM_W-1:0] cmd_y,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ELEM_W-1:0] rsp_root,
    output logic [1:0]        uf_op,
    output logic [ELEM_W-1:0] uf_x,
    output logic [ELEM_W-1:0] uf_y,
    input  logic [ELEM_W-1:0] uf_root,
    output logic              busy,
    output logic [7:0]        err_cnt
);

    if (ELEM_W != UF_ELEM_W) begin : g_bad_elem_w
        $error("uf_op_issuer: ELEM_W must equal uf_pkg::UF_ELEM_W");
    end
    if (SIZE == 0 || SIZE > (32'd1 << ELEM_W)) begin : g_bad_size
        $error("uf_op_issuer: SIZE must be in 1..2**ELEM_W");
    end

    uf_state_e         state_q, state_d;
    logic [1:0]        uf_op_q, uf_op_d;
    logic [ELEM_W-1:0] uf_x_q, uf_x_d;
    logic [ELEM_W-1:0] uf_y_q, uf_y_d;
    logic [ELEM_W-1:0] rsp_root_q, rsp_root_d;
    logic              rsp_valid_q, rsp_valid_d;

    uf_cmd_t in_cmd;
    uf_cmd_t head;
    logic    fifo_full;
    logic    fifo_empty;
    logic    push;
    logic    pop;
    logic    op_legal;
    logic    in_range;

    assign op_legal = (cmd_op == UF_OP_UNION) || (cmd_op == UF_OP_FIND);

`ifdef UF_RANGE_CHECK_EN
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       reject;

    assign in_range = (32'(cmd_x) < SIZE) &&
                      ((cmd_op != UF_OP_UNION) || (32'(cmd_y) < SIZE));
    assign reject   = cmd_valid && cmd_ready && op_legal && !in_range;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (reject && err_cnt_q != 8'hff) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign in_range = 1'b1;
    assign err_cnt  = '0;
`endif

    // NOP/reserved and rejected commands are handshaken but never enter the FIFO.
    assign cmd_ready = !fifo_full;
    assign push      = cmd_valid && cmd_ready && op_legal && in_range;
    assign in_cmd    = '{op: cmd_op, x: cmd_x, y: cmd_y};

    uf_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (in_cmd),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        uf_op_d     = UF_OP_NOP;
        uf_x_d      = uf_x_q;
        uf_y_d      = uf_y_q;
        rsp_root_d  = rsp_root_q;
        rsp_valid_d = rsp_valid_q;
        pop         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    uf_op_d = head.op;
                    uf_x_d  = head.x;
                    uf_y_d  = head.y;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = (uf_op_q == UF_OP_FIND) ? ST_WAIT : ST_IDLE;
            end
            ST_WAIT: begin
                rsp_root_d  = uf_root;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            uf_op_q     <= UF_OP_NOP;
            uf_x_q      <= '0;
            uf_y_q      <= '0;
            rsp_root_q  <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            uf_op_q     <= uf_op_d;
            uf_x_q      <= uf_x_d;
            uf_y_q      <= uf_y_d;
            rsp_root_q  <= rsp_root_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign uf_op     = uf_op_q;
    assign uf_x      = uf_x_q;
    assign uf_y      = uf_y_q;
    assign rsp_root  = rsp_root_q;
    assign rsp_valid = rsp_valid_q;
    assign busy      = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_uf_op_issuer.sv
// Directed bench for uf_op_issuer with a behavioural union-find core attached.
module tb_uf_op_issuer;

    localparam logic [1:0] OP_NOP = 2'd0;
    localparam logic [1:0] OP_UN  = 2'd1;
    localparam logic [1:0] OP_FD  = 2'd2;
    localparam logic [1:0] OP_RS  = 2'd3;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_x;
    logic [3:0] cmd_y;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_root;
    logic [1:0] uf_op;
    logic [3:0] uf_x;
    logic [3:0] uf_y;
    logic [3:0] uf_root;
    logic       busy;
    logic [7:0] err_cnt;

    int n_vec = 0;
    int n_err = 0;

    uf_op_issuer #(
        .SIZE       (10),
        .ELEM_W     (4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_root  (rsp_root),
        .uf_op     (uf_op),
        .uf_x      (uf_x),
        .uf_y      (uf_y),
        .uf_root   (uf_root),
        .busy      (busy),
        .err_cnt   (err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Union-find core: union(x,y) hangs root(y) under root(x); find registers root(x).
    logic [3:0] parent [16];

    function automatic logic [3:0] root_of(input logic [3:0] e);
        logic [3:0] r;
        r = e;
        for (int i = 0; i < 16; i++) begin
            if (parent[r] != r) r = parent[r];
        end
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) parent[i] <= 4'(i);
            uf_root <= '0;
        end else begin
            if (uf_op == OP_UN) parent[root_of(uf_y)] <= root_of(uf_x);
            if (uf_op == OP_FD) uf_root <= root_of(uf_x);
        end
    end

    int         n_ops;
    int         n_union;
    int         n_union_pulse;
    int         n_find;
    logic [3:0] last_find_x;
    logic [1:0] prev_op;
    logic [3:0] rsp_q [$];

    always @(negedge clk) begin
        if (uf_op != OP_NOP) n_ops++;
        if (uf_op == OP_UN) n_union++;
        if (uf_op == OP_UN && prev_op != OP_UN) n_union_pulse++;
        if (uf_op == OP_FD) begin
            n_find++;
            last_find_x = uf_x;
        end
        prev_op = uf_op;
        if (rsp_valid && rsp_ready) rsp_q.push_back(rsp_root);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        n_ops         = 0;
        n_union       = 0;
        n_union_pulse = 0;
        n_find        = 0;
        rsp_q.delete();
    endtask

    task automatic push(input logic [1:0] op, input logic [3:0] x, input logic [3:0] y);
        int n;
        n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_x     = x;
        cmd_y     = y;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("push_timeout", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n, input int budget);
        int c;
        c = 0;
        while (rsp_q.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
    endtask

    function automatic logic [31:0] rsp_at(input int i);
        if (i < rsp_q.size()) return 32'(rsp_q[i]);
        return 'x;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [3:0] tbl [6];
    int         acc;
    logic       hs;
    logic [3:0] exp_tbl [6];

    initial begin
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_x     = '0;
        cmd_y     = '0;
        rsp_ready = 1'b1;
        prev_op   = OP_NOP;
        clear_stats();
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_root",  32'(rsp_root),  32'd0);
        check("rst_uf_op",     32'(uf_op),     32'd0);
        check("rst_uf_x",      32'(uf_x),      32'd0);
        check("rst_uf_y",      32'(uf_y),      32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_err_cnt",   32'(err_cnt),   32'd0);

        // Single find: accept E0, issue after E1, core E2, response after E3.
        push(OP_FD, 4'd3, 4'd0);
        check("f1_busy_e0",  32'(busy),      32'd1);
        check("f1_op_e0",    32'(uf_op),     32'd0);
        @(posedge clk); #1;
        check("f1_op_e1",    32'(uf_op),     32'd2);
        check("f1_x_e1",     32'(uf_x),      32'd3);
        @(posedge clk); #1;
        check("f1_op_e2",    32'(uf_op),     32'd0);
        check("f1_valid_e2", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        check("f1_valid_e3", 32'(rsp_valid), 32'd1);
        check("f1_root_e3",  32'(rsp_root),  32'd3);
        @(posedge clk); #1;
        check("f1_valid_e4", 32'(rsp_valid), 32'd0);
        check("f1_busy_e4",  32'(busy),      32'd0);

        // union(1,2), union(2,5), find 5 -> root 1
        clear_stats();
        push(OP_UN, 4'd1, 4'd2);
        push(OP_UN, 4'd2, 4'd5);
        push(OP_FD, 4'd5, 4'd0);
        wait_rsp(1, 40);
        repeat (3) @(negedge clk);
        check("u2_rsp_cnt",     32'(rsp_q.size()),  32'd1);
        check("u2_root",        rsp_at(0),          32'd1);
        check("u2_union_cyc",   32'(n_union),       32'd2);
        check("u2_union_pulse", 32'(n_union_pulse), 32'd2);
        check("u2_find_cyc",    32'(n_find),        32'd1);

        // Back-pressure: 6 finds offered, rsp_ready low.
        clear_stats();
        tbl     = '{4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd3};
        exp_tbl = '{4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd3};
        @(posedge clk); #1 rsp_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            cmd_valid = (acc < 6);
            cmd_op    = OP_FD;
            cmd_x     = (acc < 6) ? tbl[acc] : 4'd0;
            hs        = cmd_valid && cmd_ready;
            @(posedge clk);
            if (hs) acc++;
        end
        #1;
        check("bp_accepted",  32'(acc),       32'd5);
        check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        check("bp_valid",     32'(rsp_valid), 32'd1);
        check("bp_root",      32'(rsp_root),  32'd6);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(rsp_valid), 32'd1);
            check("bp_hold_root",  32'(rsp_root),  32'd6);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        for (int c = 0; c < 40 && acc < 6; c++) begin
            @(negedge clk);
            cmd_valid = (acc < 6);
            cmd_op    = OP_FD;
            cmd_x     = (acc < 6) ? tbl[acc] : 4'd0;
            hs        = cmd_valid && cmd_ready;
            @(posedge clk);
            if (hs) acc++;
        end
        #1 cmd_valid = 1'b0;
        check("bp_accepted_all", 32'(acc), 32'd6);
        wait_rsp(6, 80);
        check("bp_rsp_cnt", 32'(rsp_q.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("bp_order%0d", i), rsp_at(i), 32'(exp_tbl[i]));
        end

        // NOP / reserved interleaved with union(0,4)
        repeat (2) @(negedge clk);
        clear_stats();
        push(OP_NOP, 4'd0, 4'd0);
        push(OP_RS,  4'd1, 4'd1);
        push(OP_UN,  4'd0, 4'd4);
        push(OP_NOP, 4'd2, 4'd3);
        push(OP_RS,  4'd5, 4'd6);
        repeat (10) @(negedge clk);
        check("nop_ops",     32'(n_ops),        32'd1);
        check("nop_union",   32'(n_union),      32'd1);
        check("nop_rsp_cnt", 32'(rsp_q.size()), 32'd0);
        check("nop_busy",    32'(busy),         32'd0);
        push(OP_FD, 4'd4, 4'd0);
        wait_rsp(1, 20);
        check("nop_find4", rsp_at(0), 32'd0);

        // Out-of-range indices
        repeat (2) @(negedge clk);
        clear_stats();
        push(OP_FD, 4'd12, 4'd0);
        push(OP_UN, 4'd2,  4'd15);
        repeat (12) @(negedge clk);
`ifdef UF_RANGE_CHECK_EN
        check("rng_ops",     32'(n_ops),        32'd0);
        check("rng_err_cnt", 32'(err_cnt),      32'd2);
        check("rng_rsp_cnt", 32'(rsp_q.size()), 32'd0);
`else
        check("rng_find",    32'(n_find),       32'd1);
        check("rng_find_x",  32'(last_find_x),  32'd12);
        check("rng_union",   32'(n_union),      32'd1);
        check("rng_err_cnt", 32'(err_cnt),      32'd0);
        check("rng_rsp",     rsp_at(0),         32'd12);
`endif

        // Reset while holding a response, with another find queued
        @(posedge clk); #1 rsp_ready = 1'b0;
        clear_stats();
        push(OP_FD, 4'd7, 4'd0);
        push(OP_FD, 4'd3, 4'd0);
        for (int c = 0; c < 20 && !rsp_valid; c++) @(negedge clk);
        check("rr_pre_valid", 32'(rsp_valid), 32'd1);
        @(posedge clk); #2 rst = 1'b1;
        #1;
        check("rr_valid",     32'(rsp_valid), 32'd0);
        check("rr_busy",      32'(busy),      32'd0);
        check("rr_uf_op",     32'(uf_op),     32'd0);
        check("rr_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rr_root",      32'(rsp_root),  32'd0);
        @(negedge clk);
        rst       = 1'b0;
        rsp_ready = 1'b1;
        clear_stats();
        push(OP_FD, 4'd8, 4'd0);
        wait_rsp(1, 20);
        repeat (10) @(negedge clk);
        check("rr_rsp_cnt", 32'(rsp_q.size()), 32'd1);
        check("rr_new_root", rsp_at(0), 32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
